vector_serializer: RTL
======================

VECTOR_SERIALIZER -- requirements
Module: vector_serializer

Interface
REQ-001 Parameter WIDTH, default 16: bit width of one data element.
REQ-002 Parameter LEN, default 8: elements per vector; legal range 1..256.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  LEN*WIDTH  parallel vector; element k at bits [k*WIDTH +: WIDTH].
REQ-006 in_valid  input  1  in_data holds a valid vector.
REQ-007 in_ready  output  1  serializer accepts a vector this cycle.
REQ-008 out_data  output  WIDTH  current serial element.
REQ-009 out_valid  output  1  out_data holds a valid element.
REQ-010 out_ready  input  1  downstream accepts the element this cycle.
REQ-011 out_last  output  1  high with out_valid on the final element (index LEN-1) of a vector.
REQ-012 busy  output  1  a vector is held and not yet fully sent.

Function
REQ-013 Input handshake: vector accepted on a rising edge where in_valid && in_ready; output handshake: element transferred where out_valid && out_ready.
REQ-014 State machine: two states, IDLE and SEND.
REQ-015 IDLE: in_ready=1, out_valid=0; on input handshake, capture in_data into a LEN-entry buffer, clear element index idx to 0, go to SEND.
REQ-016 SEND: out_valid=1; out_data=buffer[idx]; out_last=(idx==LEN-1); busy=1.
REQ-017 SEND, output handshake with idx<LEN-1: idx increments by 1; stay in SEND.
REQ-018 SEND, output handshake with idx==LEN-1, in_valid=0: go to IDLE.
REQ-019 SEND, output handshake with idx==LEN-1, in_valid=1: capture new vector, idx to 0, stay in SEND; no bubble cycle.
REQ-020 in_ready is combinational: 1 in IDLE; 1 in SEND only when idx==LEN-1 && out_ready; otherwise 0.
REQ-021 in_valid/in_data are ignored whenever in_ready=0; the buffer never changes outside an input handshake.
REQ-022 out_ready=0 in SEND: out_data, out_last, idx and buffer are held unchanged.
REQ-023 Latency: vector accepted at edge N; element 0 appears on out_data after edge N (cycle N+1).
REQ-024 Element order: index 0 first, ascending to LEN-1.
REQ-025 Throughput: with out_ready and in_valid held high, one element per cycle, one vector per LEN cycles.
REQ-026 idx width is max(1,$clog2(LEN)); it never exceeds LEN-1.
REQ-027 LEN=1: every element carries out_last=1; in SEND, in_ready equals out_ready.
REQ-028 out_valid, out_last and busy are registered-state decodes; none depends combinationally on in_valid.
REQ-029 out_data is don't-care when out_valid=0 but holds the last buffer value, not X, after the first capture.

Reset
REQ-030 rst asserted: state=IDLE, idx=0, buffer all zeros, out_valid=0, out_last=0, busy=0; in_ready=1 one cycle after rst deasserts.
REQ-031 rst asserted mid-vector: remaining elements are dropped; no element is emitted after reset until a new input handshake.
REQ-032 No input handshake is taken while rst is high.

Verification (LEN=4, WIDTH=8)
REQ-033 Single vector {0x44,0x33,0x22,0x11} (element 0 = 0x11), out_ready=1 -> out_data 0x11,0x22,0x33,0x44 in four consecutive cycles starting cycle N+1; out_last only on 0x44; then IDLE.
REQ-034 Back-to-back vectors A then B, in_valid and out_ready held high -> eight consecutive valid elements with no gap; in_ready pulses exactly on A's last element.
REQ-035 Backpressure: out_ready low for 3 cycles while element 1 is presented -> out_data stays 0x22, idx holds; stream resumes with 0x33.
REQ-036 in_valid asserted with changing in_data during elements 0..2 -> ignored; only data present at the last-element handshake is captured.
REQ-037 rst pulsed while element 2 is presented -> out_valid=0 immediately; busy=0; next vector starts cleanly at element 0.
REQ-038 LEN=1 build: each vector emits one element with out_last=1; continuous in_valid gives one element per cycle.

Source files
------------

// File: rtl/vector_serializer.sv
// Loads a LEN-element parallel vector and emits it one element per handshake, element 0 first.
// Element 0 is valid the cycle after capture. A new vector can be taken on the last element's handshake.
module vector_serializer #(
  parameter int WIDTH = 16,
  parameter int LEN   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LEN*WIDTH-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);

  localparam int IDXW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [LEN*WIDTH-1:0]   buf_q, buf_d;
  logic                   at_last;

  assign at_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d   = in_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = at_last;
        in_ready  = at_last && out_ready;
        if (out_ready) begin
          if (!at_last) begin
            idx_d = idx_q + 1'b1;
          end else if (in_valid) begin
            // Reload on the final handshake so back-to-back vectors have no bubble.
            buf_d = in_data;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // idx is left untouched on return to IDLE, so out_data keeps showing a buffered element.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < LEN; k++) begin
      if (idx_q == IDXW'(k)) out_data = buf_q[k*WIDTH +: WIDTH];
    end
  end

endmodule
